// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore outputs per state; pcen and illegal_op mix in zero/op.
module multicycle_ctrl_fsm #(
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    // Plain vector register so the unused codes 12-15 stay representable.
    logic [3:0] state;
    state_t     next_state;
    logic       pcwrite;
    logic       branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW:    next_state = MEMADR;
                    OP_SW:    next_state = MEMADR;
                    OP_RTYPE: next_state = RTYPEEX;
                    OP_BEQ:   next_state = BEQEX;
                    OP_ADDI:  next_state = ADDIEX;
                    OP_J:     next_state = JEX;
                    default:  next_state = FETCH;
                endcase
            end
            MEMADR: begin
                if (op == OP_LW) begin
                    next_state = MEMRD;
                end else if (op == OP_SW) begin
                    next_state = MEMWR;
                end else begin
                    next_state = FETCH;
                end
            end
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        iord       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        pcsrc      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (state)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = (op != OP_LW) && (op != OP_SW) &&
                             (op != OP_RTYPE) && (op != OP_BEQ) &&
                             (op != OP_ADDI) && (op != OP_J);
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                branch  = 1'b1;
                pcsrc   = 2'b01;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: begin
            end
        endcase
        pcen = pcwrite | (branch & zero);
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for the multicycle control FSM.
// Expected state/output pairs are queued per instruction, then popped per cycle.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;
    logic       illegal_op;
    logic [3:0] state_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [14:0] out;
    } exp_t;

    exp_t sbq[$];

    logic [14:0] obs;
    assign obs = {iord, irwrite, memwrite, regdst, memtoreg, regwrite,
                  alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op};

    multicycle_ctrl_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .pcen       (pcen),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference output table, one row per state.
    function automatic logic [14:0] exp_out(logic [3:0] s, logic [5:0] o,
                                            logic z);
        logic io, ir, mw, rd, mr, rw, sa, pcw, br, ill;
        logic [1:0] sb, ao, ps;
        io = 0; ir = 0; mw = 0; rd = 0; mr = 0; rw = 0; sa = 0;
        pcw = 0; br = 0; ill = 0; sb = 0; ao = 0; ps = 0;
        case (s)
            4'd0:  begin ir = 1; pcw = 1; sb = 2'b01; end
            4'd1:  begin
                sb  = 2'b11;
                ill = !(o inside {6'b100011, 6'b101011, 6'b000000,
                                  6'b000100, 6'b001000, 6'b000010});
            end
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin io = 1; end
            4'd4:  begin rw = 1; mr = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; br = 1; ps = 2'b01; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: begin rw = 1; end
            4'd11: begin pcw = 1; ps = 2'b10; end
            default: begin end
        endcase
        return {io, ir, mw, rd, mr, rw, sa, sb, ao, ps, pcw | (br & z), ill};
    endfunction

    // Starts at a negedge in FETCH; seq holds n state codes, nibble 0 first.
    task automatic run_seq(input string name, input logic [5:0] o,
                           input logic z, input logic [23:0] seq,
                           input int n);
        exp_t e;
        op   = o;
        zero = z;
        for (int i = 0; i < n; i++) begin
            sbq.push_back({seq[4*i +: 4], exp_out(seq[4*i +: 4], o, z)});
        end
        for (int i = 0; i < n; i++) begin
            #1;
            e = sbq.pop_front();
            checks++;
            if (state_o !== e.st) begin
                errors++;
                $display("FAIL %s state cyc%0d: got %0d want %0d",
                         name, i, state_o, e.st);
            end
            checks++;
            if (obs !== e.out) begin
                errors++;
                $display("FAIL %s outputs cyc%0d st%0d: got %b want %b",
                         name, i, e.st, obs, e.out);
            end
            checks++;
            if ((32'(regwrite) + 32'(memwrite) + 32'(irwrite)) > 1) begin
                errors++;
                $display("FAIL %s exclusive cyc%0d: rw%b mw%b ir%b want <=1",
                         name, i, regwrite, memwrite, irwrite);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL %s latency: state %0d after %0d cycles want 0",
                     name, state_o, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        op    = 6'b000000;
        zero  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: state %0d want 0", state_o);
        end
        checks++;
        if (obs !== exp_out(4'd0, op, zero)) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b",
                     obs, exp_out(4'd0, op, zero));
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: state %0d want 0", state_o);
        end
        reset = 1'b0;
    endtask

    task automatic test_mid_reset();
        op   = 6'b101011;
        zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (state_o !== 4'd2) begin
            errors++;
            $display("FAIL midrst_pre: state %0d want 2", state_o);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || memwrite !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: state %0d mw %b want 0 0",
                     state_o, memwrite);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abandon: state %0d mw %b rw %b want 0 0 0",
                     state_o, memwrite, regwrite);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unused_state();
        force dut.state = 4'd13;
        #1;
        checks++;
        if (state_o !== 4'd13 || obs !== 15'd0) begin
            errors++;
            $display("FAIL state13_outputs: state %0d outs %b want 13 0",
                     state_o, obs);
        end
        release dut.state;
        @(posedge clk);
        #1;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL state13_recover: state %0d want 0", state_o);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        run_seq("lw",      6'b100011, 1'b0, 24'h043210, 5);
        run_seq("sw",      6'b101011, 1'b0, 24'h005210, 4);
        run_seq("rtype",   6'b000000, 1'b0, 24'h007610, 4);
        run_seq("addi",    6'b001000, 1'b0, 24'h00A910, 4);
        run_seq("beq_z1",  6'b000100, 1'b1, 24'h000810, 3);
        run_seq("beq_z0",  6'b000100, 1'b0, 24'h000810, 3);
        run_seq("j",       6'b000010, 1'b0, 24'h000B10, 3);
        run_seq("illegal", 6'b111111, 1'b0, 24'h000010, 2);
        run_seq("illeg2",  6'b010101, 1'b1, 24'h000010, 2);
        test_mid_reset();
        run_seq("sw_post", 6'b101011, 1'b0, 24'h005210, 4);
        run_seq("b2b_lw",  6'b100011, 1'b1, 24'h043210, 5);
        test_unused_state();
        run_seq("j_post",  6'b000010, 1'b1, 24'h000B10, 3);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
